wb_reg_file: RTL and testbench

WB_REG_FILE -- requirements
Module: wb_reg_file

---
 rtl/wb_reg_file_if.sv | 35 +++
 rtl/wb_reg_file.sv | 83 ++++++++
 tb/tb_wb_reg_file.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if: bundles the writeback, read-address and status signals of
// the register file.
//   master modport - pipeline side: drives writeback controls/data and read
//                    addresses, observes read data and commit status.
//   slave modport  - register file side: the mirror image.
// clk and startin are not part of the bundle; they stay plain module ports.
interface wb_reg_file_if;
    logic        WB_reg_write;
    logic        WB_mem_to_reg;
    logic [31:0] WB_mem_data;
    logic [31:0] WB_alu_result;
    logic [4:0]  WB_reg_dst_mux_out;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [31:0] ID_read_data1;
    logic [31:0] ID_read_data2;
    logic [31:0] WB_write_data;
    logic [7:0]  wb_commit_count;
    logic [4:0]  last_wb_reg;
    logic [31:0] last_wb_data;

    modport master (
        output WB_reg_write, WB_mem_to_reg, WB_mem_data, WB_alu_result,
               WB_reg_dst_mux_out, ID_rs, ID_rt,
        input  ID_read_data1, ID_read_data2, WB_write_data,
               wb_commit_count, last_wb_reg, last_wb_data
    );

    modport slave (
        input  WB_reg_write, WB_mem_to_reg, WB_mem_data, WB_alu_result,
               WB_reg_dst_mux_out, ID_rs, ID_rt,
        output ID_read_data1, ID_read_data2, WB_write_data,
               wb_commit_count, last_wb_reg, last_wb_data
    );
endinterface

// File: rtl/wb_reg_file.sv
// wb_reg_file: 32 x 32-bit register file with a writeback source mux,
// two asynchronous read ports and write-through bypass, plus commit
// bookkeeping (commit counter, last destination and data).
// Ports:
//   clk     - rising-edge clock
//   startin - synchronous active-high reset: clears storage and status
//   bus     - wb_reg_file_if.slave: writeback inputs, read addresses,
//             read data, writeback value and commit status outputs
module wb_reg_file (
    input  logic              clk,
    input  logic              startin,
    wb_reg_file_if.slave      bus
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [7:0]  count_q, count_d;
    logic [4:0]  last_reg_q, last_reg_d;
    logic [31:0] last_data_q, last_data_d;

    logic [31:0] write_data;
    logic        commit;
    logic [31:0] rd1, rd2;

    always_comb begin
        write_data = bus.WB_mem_to_reg ? bus.WB_mem_data : bus.WB_alu_result;
        // A write during reset is lost, so it must neither commit nor bypass.
        commit     = !startin && bus.WB_reg_write && (bus.WB_reg_dst_mux_out != 5'd0);
    end

    always_comb begin
        regs_d      = regs_q;
        count_d     = count_q;
        last_reg_d  = last_reg_q;
        last_data_d = last_data_q;
        if (commit) begin
            regs_d[bus.WB_reg_dst_mux_out] = write_data;
            count_d     = count_q + 8'd1;
            last_reg_d  = bus.WB_reg_dst_mux_out;
            last_data_d = write_data;
        end
        regs_d[0] = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            count_q     <= 8'd0;
            last_reg_q  <= 5'd0;
            last_data_q <= 32'd0;
        end else begin
            regs_q      <= regs_d;
            count_q     <= count_d;
            last_reg_q  <= last_reg_d;
            last_data_q <= last_data_d;
        end
    end

    // Address 0 is decoded to zero explicitly so r0 reads 0 even before the
    // first reset; commit already excludes index 0, so the bypass never hits it.
    always_comb begin
        rd1 = (bus.ID_rs == 5'd0) ? 32'd0 : regs_q[bus.ID_rs];
        rd2 = (bus.ID_rt == 5'd0) ? 32'd0 : regs_q[bus.ID_rt];
        if (commit && (bus.ID_rs == bus.WB_reg_dst_mux_out)) begin
            rd1 = write_data;
        end
        if (commit && (bus.ID_rt == bus.WB_reg_dst_mux_out)) begin
            rd2 = write_data;
        end
    end

    always_comb begin
        bus.ID_read_data1   = rd1;
        bus.ID_read_data2   = rd2;
        bus.WB_write_data   = write_data;
        bus.wb_commit_count = count_q;
        bus.last_wb_reg     = last_reg_q;
        bus.last_wb_data    = last_data_q;
    end

endmodule

// File: tb/tb_wb_reg_file.sv
module tb_wb_reg_file;

    localparam int K_RD1   = 0;
    localparam int K_RD2   = 1;
    localparam int K_WBD   = 2;
    localparam int K_CNT   = 3;
    localparam int K_LREG  = 4;
    localparam int K_LDATA = 5;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } item_t;

    logic clk;
    logic startin;
    wb_reg_file_if bus();

    wb_reg_file dut (
        .clk     (clk),
        .startin (startin),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    logic [7:0]  model_cnt;

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_RD1:   return bus.ID_read_data1;
            K_RD2:   return bus.ID_read_data2;
            K_WBD:   return bus.WB_write_data;
            K_CNT:   return {24'd0, bus.wb_commit_count};
            K_LREG:  return {27'd0, bus.last_wb_reg};
            default: return bus.last_wb_data;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input logic [31:0] exp);
        item_t it;
        it.tag  = tag;
        it.kind = kind;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    // Settle, then pop every pending expectation and compare with the DUT.
    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.kind);
            checks++;
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic we, input logic m2r, input logic [31:0] md,
                            input logic [31:0] alu, input logic [4:0] dst);
        bus.WB_reg_write       = we;
        bus.WB_mem_to_reg      = m2r;
        bus.WB_mem_data        = md;
        bus.WB_alu_result      = alu;
        bus.WB_reg_dst_mux_out = dst;
    endtask

    initial begin
        logic [4:0]  dst;
        logic [31:0] val;

        startin = 1'b1;
        drive_wb(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.ID_rs = 5'd5;
        bus.ID_rt = 5'd6;

        // Reset state.
        step();
        expect_val("rst_rd1", K_RD1, 32'd0);
        expect_val("rst_rd2", K_RD2, 32'd0);
        expect_val("rst_cnt", K_CNT, 32'd0);
        expect_val("rst_lreg", K_LREG, 32'd0);
        expect_val("rst_ldata", K_LDATA, 32'd0);
        drain();

        // Load from memory into r25.
        startin = 1'b0;
        drive_wb(1'b1, 1'b1, 32'h11111111, 32'hAABBCCDD, 5'd25);
        bus.ID_rs = 5'd25;
        expect_val("load_wbd", K_WBD, 32'h11111111);
        expect_val("load_bypass", K_RD1, 32'h11111111);
        drain();
        step();
        drive_wb(1'b0, 1'b1, 32'h0, 32'h0, 5'd0);
        expect_val("load_rd1", K_RD1, 32'h11111111);
        expect_val("load_cnt", K_CNT, 32'd1);
        expect_val("load_lreg", K_LREG, 32'd25);
        expect_val("load_ldata", K_LDATA, 32'h11111111);
        drain();

        // Bypass on both ports from the ALU path.
        drive_wb(1'b1, 1'b0, 32'h99999999, 32'hBBCCDDEE, 5'd21);
        bus.ID_rs = 5'd21;
        bus.ID_rt = 5'd21;
        expect_val("byp_rd1", K_RD1, 32'hBBCCDDEE);
        expect_val("byp_rd2", K_RD2, 32'hBBCCDDEE);
        expect_val("byp_wbd", K_WBD, 32'hBBCCDDEE);
        drain();
        // Port 2 not on the destination: no bypass there.
        bus.ID_rt = 5'd25;
        expect_val("byp_rd2_other", K_RD2, 32'h11111111);
        expect_val("byp_rd1_still", K_RD1, 32'hBBCCDDEE);
        drain();
        step();
        drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        expect_val("byp_r21", K_RD1, 32'hBBCCDDEE);
        expect_val("byp_r25", K_RD2, 32'h11111111);
        expect_val("byp_cnt", K_CNT, 32'd2);
        expect_val("byp_lreg", K_LREG, 32'd21);
        drain();

        // r0 protection.
        drive_wb(1'b1, 1'b0, 32'h0, 32'hCCDDEEFF, 5'd0);
        bus.ID_rs = 5'd0;
        bus.ID_rt = 5'd0;
        expect_val("r0_during", K_RD1, 32'd0);
        expect_val("r0_during2", K_RD2, 32'd0);
        drain();
        step();
        drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        expect_val("r0_after", K_RD1, 32'd0);
        expect_val("r0_cnt", K_CNT, 32'd2);
        expect_val("r0_lreg", K_LREG, 32'd21);
        expect_val("r0_ldata", K_LDATA, 32'hBBCCDDEE);
        drain();

        // Disabled write.
        drive_wb(1'b0, 1'b1, 32'h33333333, 32'h44444444, 5'd13);
        bus.ID_rs = 5'd13;
        expect_val("dis_wbd", K_WBD, 32'h33333333);
        expect_val("dis_nobyp", K_RD1, 32'd0);
        drain();
        step();
        expect_val("dis_r13", K_RD1, 32'd0);
        expect_val("dis_cnt", K_CNT, 32'd2);
        expect_val("dis_lreg", K_LREG, 32'd21);
        expect_val("dis_ldata", K_LDATA, 32'hBBCCDDEE);
        drain();

        // Reset with a simultaneous valid write.
        startin = 1'b1;
        drive_wb(1'b1, 1'b1, 32'h55555555, 32'h0, 5'd25);
        bus.ID_rs = 5'd25;
        bus.ID_rt = 5'd21;
        expect_val("rstw_nobyp1", K_RD1, 32'h11111111);
        expect_val("rstw_nobyp2", K_RD2, 32'hBBCCDDEE);
        drain();
        step();
        startin = 1'b0;
        drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        expect_val("rstw_r25", K_RD1, 32'd0);
        expect_val("rstw_r21", K_RD2, 32'd0);
        expect_val("rstw_cnt", K_CNT, 32'd0);
        expect_val("rstw_lreg", K_LREG, 32'd0);
        expect_val("rstw_ldata", K_LDATA, 32'd0);
        drain();

        // 256 commits rotating through r1..r31; counter wraps to 0.
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_cnt = 8'd0;
        bus.ID_rt = 5'd0;
        for (int i = 0; i < 256; i++) begin
            dst = 5'((i % 31) + 1);
            val = $urandom();
            drive_wb(1'b1, i[0], val, ~val, dst);
            if (i[0]) model[dst] = val;
            else      model[dst] = ~val;
            model_cnt = model_cnt + 8'd1;
            step();
            drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
            expect_val("wrap_cnt", K_CNT, {24'd0, model_cnt});
            expect_val("wrap_lreg", K_LREG, {27'd0, dst});
            expect_val("wrap_ldata", K_LDATA, model[dst]);
            if (i == 254) expect_val("wrap_cnt255", K_CNT, 32'd255);
            if (i == 255) expect_val("wrap_cnt0", K_CNT, 32'd0);
            drain();
        end

        // Storage contents after the rotation.
        for (int r = 1; r < 32; r++) begin
            bus.ID_rs = 5'(r);
            bus.ID_rt = 5'(32 - r);
            expect_val("final_rd1", K_RD1, model[r]);
            expect_val("final_rd2", K_RD2, model[32 - r]);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
